draw_car: RTL and testbench

Pipelined sprite-overlay stage that sits directly downstream of the XGA timing generator. It overlays a 64×96 car bitmap, fetched from an external synchronous ROM, onto the incoming pixel stream. It forwards all timing signals delayed to match its 3-cycle pipeline. The sprite position is latched once per frame at the start of vertical blanking, so the car never tears mid-frame.

---
 rtl/draw_car.sv | 162 ++++++++++++++++
 tb/tb_draw_car.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/draw_car.sv
// Sprite-overlay pipeline stage: composites a 64x96 car bitmap read from an
// external synchronous ROM onto the pixel stream from the timing generator.
// Three register stages; every timing signal is delayed to stay aligned with
// the composited colour. The sprite position is captured once per frame on
// the rising edge of vertical blanking so the car never tears mid-frame.
module draw_car #(
    parameter int          X_SIZE      = 64,
    parameter int          Y_SIZE      = 96,
    parameter int          ADDR_W      = 13,
    parameter logic [11:0] TRANSPARENT = 12'h0F0
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic [10:0]       hcount_in,
    input  logic [10:0]       vcount_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [10:0]       hcount_out,
    output logic [10:0]       vcount_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out
);

    // Column bits come straight from rel_x; the remaining address bits are rows.
    localparam int XW = $clog2(X_SIZE);
    localparam int YW = ADDR_W - XW;

    logic        vblnk_prev;
    logic [10:0] xpos_l;
    logic [10:0] ypos_l;

    // Only the low bits of the offsets reach the ROM address, so the
    // subtraction is done at that width (identical modulo 2^n).
    logic [XW-1:0] rel_x;
    logic [YW-1:0] rel_y;
    logic [11:0]   x_end;
    logic [11:0]   y_end;
    logic          in_box;

    logic [10:0] hcount_d1, vcount_d1, hcount_d2, vcount_d2;
    logic        hsync_d1, hblnk_d1, vsync_d1, vblnk_d1;
    logic        hsync_d2, hblnk_d2, vsync_d2, vblnk_d2;
    logic [11:0] rgb_d1, rgb_d2;
    logic        in_box_d1, in_box_d2;
    logic [11:0] rgb_next;

    // Capture the requested position on the rising edge of vertical blanking.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev <= 1'b0;
            xpos_l     <= '0;
            ypos_l     <= '0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_in && !vblnk_prev) begin
                xpos_l <= xpos;
                ypos_l <= ypos;
            end
        end
    end

    // Box test; the end coordinates are one bit wider so a sprite hanging
    // past the right/bottom edge is clipped instead of wrapping to column 0.
    always_comb begin
        rel_x  = hcount_in[XW-1:0] - xpos_l[XW-1:0];
        rel_y  = vcount_in[YW-1:0] - ypos_l[YW-1:0];
        x_end  = {1'b0, xpos_l} + 12'(X_SIZE);
        y_end  = {1'b0, ypos_l} + 12'(Y_SIZE);
        in_box = (hcount_in >= xpos_l) && ({1'b0, hcount_in} < x_end) &&
                 (vcount_in >= ypos_l) && ({1'b0, vcount_in} < y_end) &&
                 !hblnk_in && !vblnk_in;
    end

    // Stage 1: issue the ROM address and register the incoming pixel.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= '0;
            in_box_d1 <= 1'b0;
            hcount_d1 <= '0;
            vcount_d1 <= '0;
            hsync_d1  <= 1'b0;
            hblnk_d1  <= 1'b0;
            vsync_d1  <= 1'b0;
            vblnk_d1  <= 1'b0;
            rgb_d1    <= '0;
        end else begin
            rom_addr  <= in_box ? {rel_y, rel_x} : '0;
            in_box_d1 <= in_box;
            hcount_d1 <= hcount_in;
            vcount_d1 <= vcount_in;
            hsync_d1  <= hsync_in;
            hblnk_d1  <= hblnk_in;
            vsync_d1  <= vsync_in;
            vblnk_d1  <= vblnk_in;
            rgb_d1    <= rgb_in;
        end
    end

    // Stage 2: wait for the ROM's registered read to land.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            in_box_d2 <= 1'b0;
            hcount_d2 <= '0;
            vcount_d2 <= '0;
            hsync_d2  <= 1'b0;
            hblnk_d2  <= 1'b0;
            vsync_d2  <= 1'b0;
            vblnk_d2  <= 1'b0;
            rgb_d2    <= '0;
        end else begin
            in_box_d2 <= in_box_d1;
            hcount_d2 <= hcount_d1;
            vcount_d2 <= vcount_d1;
            hsync_d2  <= hsync_d1;
            hblnk_d2  <= hblnk_d1;
            vsync_d2  <= vsync_d1;
            vblnk_d2  <= vblnk_d1;
            rgb_d2    <= rgb_d1;
        end
    end

    // Colour select: blanking forces black, then background, then sprite.
    always_comb begin
        rgb_next = rom_data;
        if (hblnk_d2 || vblnk_d2)
            rgb_next = 12'h000;
        else if (!in_box_d2 || rom_data == TRANSPARENT)
            rgb_next = rgb_d2;
    end

    // Stage 3: register the composited pixel and the aligned timing.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_d2;
            vcount_out <= vcount_d2;
            hsync_out  <= hsync_d2;
            hblnk_out  <= hblnk_d2;
            vsync_out  <= vsync_d2;
            vblnk_out  <= vblnk_d2;
            rgb_out    <= rgb_next;
        end
    end

endmodule

// File: tb/tb_draw_car.sv
// Directed bench for draw_car: a vector table of pixels with hand-computed
// composited colours, streamed through the 3-cycle pipeline, plus
// hand-written sequences for reset release and mid-frame reset.
module tb_draw_car;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b1, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [10:0] xpos = '0, ypos = '0;
    logic [12:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    draw_car dut (
        .pclk(pclk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    // Synchronous ROM: one cycle latency, address 5 holds the key colour.
    always @(posedge pclk)
        rom_data <= (rom_addr == 13'd5) ? 12'h0F0 : {1'b1, rom_addr[10:0]};

    typedef struct {
        logic [10:0] h, v;
        logic        hb, vb;
        logic [10:0] x, y;
        logic [11:0] rgb;
        logic [11:0] exp;
    } vec_t;

    localparam int NV = 43;
    vec_t vecs [NV];

    function automatic vec_t mk(int h, int v, bit hb, bit vb, int x, int y,
                                logic [11:0] rgb, logic [11:0] exp);
        vec_t r;
        r.h = 11'(h); r.v = 11'(v); r.hb = hb; r.vb = vb;
        r.x = 11'(x); r.y = 11'(y); r.rgb = rgb; r.exp = exp;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [10:0] h, logic [10:0] v, logic hs, logic hb,
                         logic vs, logic vb, logic [10:0] x, logic [10:0] y,
                         logic [11:0] rgb);
        hcount_in = h; vcount_in = v; hsync_in = hs; hblnk_in = hb;
        vsync_in = vs; vblnk_in = vb; xpos = x; ypos = y; rgb_in = rgb;
    endtask

    // Stream vecs[lo..hi-1] one per clock; each output is checked 3 cycles later.
    task automatic run_vectors(int lo, int hi);
        int cnt = hi - lo;
        for (int k = 0; k < cnt + 3; k++) begin
            @(negedge pclk);
            if (k >= 3) begin
                int i = lo + k - 3;
                logic hs, vs;
                hs = i[0];
                vs = i[1];
                check($sformatf("rgb[%0d]", i), 32'(rgb_out), 32'(vecs[i].exp));
                check($sformatf("timing[%0d]", i),
                      32'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}),
                      32'({vecs[i].h, vecs[i].v, hs, vecs[i].hb, vs, vecs[i].vb}));
                $display("vec %0d: h=%0d v=%0d hb=%0b vb=%0b rgb_out=%h exp=%h",
                         i, vecs[i].h, vecs[i].v, vecs[i].hb, vecs[i].vb, rgb_out, vecs[i].exp);
            end
            if (k < cnt) begin
                int j = lo + k;
                drive(vecs[j].h, vecs[j].v, j[0], vecs[j].hb, j[1], vecs[j].vb,
                      vecs[j].x, vecs[j].y, vecs[j].rgb);
            end else begin
                drive(11'd0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, xpos, ypos, 12'h000);
            end
        end
    endtask

    initial begin
        // Basic overlay at (100,200); ROM word = {1, addr[10:0]}
        vecs[0]  = mk(0,    0,   0, 1, 100, 200, 12'hABC, 12'h000);
        vecs[1]  = mk(100,  200, 0, 0, 100, 200, 12'hABC, 12'h800);
        vecs[2]  = mk(101,  200, 0, 0, 100, 200, 12'hABC, 12'h801);
        vecs[3]  = mk(104,  200, 0, 0, 100, 200, 12'hABC, 12'h804);
        vecs[4]  = mk(105,  200, 0, 0, 100, 200, 12'hABC, 12'hABC);
        vecs[5]  = mk(106,  200, 0, 0, 100, 200, 12'hABC, 12'h806);
        vecs[6]  = mk(99,   200, 0, 0, 100, 200, 12'hABC, 12'hABC);
        vecs[7]  = mk(164,  200, 0, 0, 100, 200, 12'hABC, 12'hABC);
        vecs[8]  = mk(163,  200, 0, 0, 100, 200, 12'hABC, 12'h83F);
        vecs[9]  = mk(163,  295, 0, 0, 100, 200, 12'hABC, 12'hFFF);
        vecs[10] = mk(100,  295, 0, 0, 100, 200, 12'hABC, 12'hFC0);
        vecs[11] = mk(100,  296, 0, 0, 100, 200, 12'hABC, 12'hABC);
        vecs[12] = mk(100,  199, 0, 0, 100, 200, 12'hABC, 12'hABC);
        vecs[13] = mk(120,  210, 1, 0, 100, 200, 12'hABC, 12'h000);
        vecs[14] = mk(120,  210, 0, 1, 100, 200, 12'hABC, 12'h000);
        // xpos moved mid-frame: still drawn at 100 until next vblank rise
        vecs[15] = mk(100,  250, 0, 0, 300, 200, 12'h123, 12'hC80);
        vecs[16] = mk(300,  250, 0, 0, 300, 200, 12'h123, 12'h123);
        vecs[17] = mk(0,    0,   0, 1, 300, 200, 12'hABC, 12'h000);
        vecs[18] = mk(100,  250, 0, 0, 300, 200, 12'hABC, 12'hABC);
        vecs[19] = mk(300,  250, 0, 0, 300, 200, 12'hABC, 12'hC80);
        vecs[20] = mk(301,  251, 0, 0, 300, 200, 12'hABC, 12'hCC1);
        // Right-edge clipping at xpos=1000
        vecs[21] = mk(0,    0,   0, 1, 1000, 200, 12'hABC, 12'h000);
        vecs[22] = mk(1000, 210, 0, 0, 1000, 200, 12'hABC, 12'hA80);
        vecs[23] = mk(1023, 210, 0, 0, 1000, 200, 12'hABC, 12'hA97);
        vecs[24] = mk(1024, 210, 1, 0, 1000, 200, 12'hABC, 12'h000);
        vecs[25] = mk(1063, 210, 1, 0, 1000, 200, 12'hABC, 12'h000);
        vecs[26] = mk(0,    210, 0, 0, 1000, 200, 12'hABC, 12'hABC);
        vecs[27] = mk(39,   210, 0, 0, 1000, 200, 12'hABC, 12'hABC);
        vecs[28] = mk(1010, 205, 0, 0, 1000, 200, 12'hABC, 12'h94A);
        // Fully off-screen sprite
        vecs[29] = mk(0,    0,   0, 1, 1100, 800, 12'hABC, 12'h000);
        vecs[30] = mk(500,  300, 0, 0, 1100, 800, 12'hABC, 12'hABC);
        vecs[31] = mk(10,   10,  0, 0, 1100, 800, 12'hABC, 12'hABC);
        // Latch only on the rising edge, not while vblank stays high
        vecs[32] = mk(0,    0,   0, 1, 0,   0,   12'hABC, 12'h000);
        vecs[33] = mk(0,    0,   0, 1, 100, 200, 12'hABC, 12'h000);
        vecs[34] = mk(100,  200, 0, 0, 100, 200, 12'hABC, 12'hABC);
        vecs[35] = mk(6,    5,   0, 0, 100, 200, 12'hABC, 12'h946);
        vecs[36] = mk(0,    0,   0, 1, 100, 200, 12'hABC, 12'h000);
        vecs[37] = mk(500,  210, 0, 0, 100, 200, 12'hABC, 12'hABC);
        // After mid-frame reset: position back at (0,0) until the next vblank rise
        vecs[38] = mk(0,    0,   0, 0, 100, 200, 12'hABC, 12'h800);
        vecs[39] = mk(100,  200, 0, 0, 100, 200, 12'hABC, 12'hABC);
        vecs[40] = mk(63,   95,  0, 0, 100, 200, 12'hABC, 12'hFFF);
        vecs[41] = mk(0,    0,   0, 1, 100, 200, 12'hABC, 12'h000);
        vecs[42] = mk(100,  200, 0, 0, 100, 200, 12'hABC, 12'h800);

        // Reset held with random inputs: everything stays at zero.
        #2 rst_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge pclk);
            check($sformatf("reset_hold[%0d]", n),
                  32'({rgb_out, hcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}) |
                  32'({vcount_out, rom_addr}), 32'd0);
            $display("reset hold %0d: rgb_out=%h hcount_out=%0d", n, rgb_out, hcount_out);
            drive(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 11'($urandom), 11'($urandom), 12'($urandom));
        end

        // Release: three flushed zeros, then hcount delayed by three cycles.
        for (int n = 0; n < 6; n++) begin
            @(negedge pclk);
            if (n == 0) rst_n = 1'b1;
            check($sformatf("release_hcount[%0d]", n), 32'(hcount_out),
                  (n >= 3) ? 32'(20 + n - 3) : 32'd0);
            $display("release %0d: hcount_out=%0d", n, hcount_out);
            drive(11'(20 + n), 11'd500, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 12'h555);
        end

        run_vectors(0, 38);

        // Mid-frame reset at hcount=500: outputs clear immediately.
        for (int n = 0; n < 4; n++) begin
            @(negedge pclk);
            drive(11'd500, 11'd210, 1'b0, 1'b0, 1'b0, 1'b0, 11'd100, 11'd200, 12'hABC);
        end
        @(negedge pclk);
        check("pre_reset_hcount", 32'(hcount_out), 32'd500);
        check("pre_reset_rgb", 32'(rgb_out), 32'h0ABC);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({rgb_out, hcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}) |
              32'({vcount_out, rom_addr}), 32'd0);
        $display("mid-frame reset: rgb_out=%h hcount_out=%0d vcount_out=%0d",
                 rgb_out, hcount_out, vcount_out);
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;

        run_vectors(38, NV);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
